// File: rtl/dp_scb_pkg.sv
// Shared types and helpers for the DP ISO lane scoreboard.
// Holds the FSM state encoding, the lane_cfg encodings and the lane-count decode.
package dp_scb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scb_state_e;

    localparam logic [1:0] LANE_CFG_1    = 2'b00;
    localparam logic [1:0] LANE_CFG_2    = 2'b01;
    localparam logic [1:0] LANE_CFG_4    = 2'b10;
    localparam logic [1:0] LANE_CFG_RSVD = 2'b11;

    // Reserved encoding falls into the 4-lane case, then everything clamps to max_lanes.
    function automatic logic [2:0] decode_lanes(input logic [1:0] cfg, input int max_lanes);
        int n;
        case (cfg)
            LANE_CFG_1: n = 1;
            LANE_CFG_2: n = 2;
            default:    n = 4;
        endcase
        if (n > max_lanes) n = max_lanes;
        return 3'(n);
    endfunction

endpackage

// File: rtl/dp_scb_fifo.sv
// Synchronous FIFO with occupancy level, simultaneous push/pop and flush.
// Read data is show-ahead: rdata always presents the oldest entry.
module dp_scb_fifo
    import dp_scb_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dp_iso_lane_scoreboard.sv
// In-order scoreboard comparing buffered reference ISO symbols against DUT lane output.
// One-cycle compare stage; reports per-lane pulses, saturating counters and sticky errors.
module dp_iso_lane_scoreboard
    import dp_scb_pkg::*;
#(
    parameter int AUX_DATA_WIDTH = 8,
    parameter int MAX_LANES      = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          lane_cfg,
    input  logic                                flush,
    input  logic                                clr_stats,
    input  logic                                exp_valid,
    input  logic [MAX_LANES*AUX_DATA_WIDTH-1:0] exp_symbols,
    input  logic [MAX_LANES-1:0]                exp_ctrl_flag,
    output logic                                exp_ready,
    input  logic                                act_valid,
    input  logic [MAX_LANES*AUX_DATA_WIDTH-1:0] act_symbols,
    input  logic [MAX_LANES-1:0]                act_ctrl_flag,
    output logic [MAX_LANES-1:0]                mismatch_lane,
    output logic [CNT_WIDTH-1:0]                mismatch_cnt,
    output logic [CNT_WIDTH-1:0]                compare_cnt,
    output logic [MAX_LANES-1:0]                lane_err_sticky,
    output logic                                overflow_err,
    output logic                                underflow_err,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic [2:0]                          active_lanes
);
    localparam int W     = AUX_DATA_WIDTH;
    localparam int SYM_W = MAX_LANES * W;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [MAX_LANES-1:0] ctrl;
        logic [SYM_W-1:0]     sym;
    } entry_t;

    entry_t               wr_ent, rd_ent, cmp_exp, cmp_act;
    logic                 full, empty, push, pop, cmp_vld;
    logic [MAX_LANES-1:0] lane_mis;
    scb_state_e           state, state_nxt;

    // A pop frees a slot this same cycle, so a full buffer can still accept.
    assign exp_ready = !flush && (!full || (act_valid && !empty));
    assign push      = exp_valid && exp_ready;
    assign pop       = act_valid && !empty && !flush;
    assign wr_ent    = '{ctrl: exp_ctrl_flag, sym: exp_symbols};

    dp_scb_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_ent),
        .rdata (rd_ent),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) cmp_vld <= 1'b0;
        else        cmp_vld <= pop;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            cmp_exp <= rd_ent;
            cmp_act <= '{ctrl: act_ctrl_flag, sym: act_symbols};
        end
    end

    for (genvar i = 0; i < MAX_LANES; i++) begin : g_lane
        assign lane_mis[i] = cmp_vld && (i < int'(active_lanes)) &&
                             ((cmp_exp.sym[i*W +: W] != cmp_act.sym[i*W +: W]) ||
                              (cmp_exp.ctrl[i] != cmp_act.ctrl[i]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_lane   <= '0;
            mismatch_cnt    <= '0;
            compare_cnt     <= '0;
            lane_err_sticky <= '0;
            overflow_err    <= 1'b0;
            underflow_err   <= 1'b0;
        end else begin
            mismatch_lane <= lane_mis;
            if (clr_stats) begin
                mismatch_cnt    <= '0;
                compare_cnt     <= '0;
                lane_err_sticky <= '0;
                overflow_err    <= 1'b0;
                underflow_err   <= 1'b0;
            end else begin
                if (cmp_vld && compare_cnt != '1)    compare_cnt  <= compare_cnt + 1'b1;
                if (|lane_mis && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                lane_err_sticky <= lane_err_sticky | lane_mis;
                if (exp_valid && !exp_ready) overflow_err  <= 1'b1;
                if (act_valid && empty)      underflow_err <= 1'b1;
            end
        end
    end

    // Lane count only tracks lane_cfg while idle so a stream is judged consistently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            active_lanes <= decode_lanes(LANE_CFG_4, MAX_LANES);
        end else begin
            state <= state_nxt;
            if (state == IDLE) active_lanes <= decode_lanes(lane_cfg, MAX_LANES);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = RUN;
            RUN: begin
                if (flush)                                         state_nxt = IDLE;
                else if (pop && !push && fifo_level == LW'(1))     state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = push ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dp_iso_lane_scoreboard.sv
// Directed bench for dp_iso_lane_scoreboard: 4 lanes, 8-bit symbols, 16-deep buffer.
module tb_dp_iso_lane_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n, flush, clr_stats, exp_valid, act_valid, exp_ready;
    logic [1:0]  lane_cfg;
    logic [31:0] exp_symbols, act_symbols;
    logic [3:0]  exp_ctrl_flag, act_ctrl_flag, mismatch_lane, lane_err_sticky;
    logic [15:0] mismatch_cnt, compare_cnt;
    logic        overflow_err, underflow_err;
    logic [4:0]  fifo_level;
    logic [2:0]  active_lanes;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  b;

    always #5 clk = ~clk;

    dp_iso_lane_scoreboard #(.AUX_DATA_WIDTH(8), .MAX_LANES(4), .FIFO_DEPTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .lane_cfg(lane_cfg), .flush(flush), .clr_stats(clr_stats),
        .exp_valid(exp_valid), .exp_symbols(exp_symbols), .exp_ctrl_flag(exp_ctrl_flag),
        .exp_ready(exp_ready), .act_valid(act_valid), .act_symbols(act_symbols),
        .act_ctrl_flag(act_ctrl_flag), .mismatch_lane(mismatch_lane), .mismatch_cnt(mismatch_cnt),
        .compare_cnt(compare_cnt), .lane_err_sticky(lane_err_sticky), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .fifo_level(fifo_level), .active_lanes(active_lanes)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; lane_cfg = 2'b10; flush = 1'b0; clr_stats = 1'b0;
        exp_valid = 1'b0; exp_symbols = '0; exp_ctrl_flag = '0;
        act_valid = 1'b0; act_symbols = '0; act_ctrl_flag = '0;
        tick(); tick();
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", exp_ready, 1);
        chk("rst_cmp", compare_cnt, 0);
        chk("rst_mis", mismatch_cnt, 0);
        chk("rst_lanes", active_lanes, 4);
        chk("rst_pulse", mismatch_lane, 0);
        chk("rst_sticky", lane_err_sticky, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_unf", underflow_err, 0);
        rst_n = 1'b1;

        // in-order match
        for (int k = 0; k < 3; k++) begin
            exp_valid = 1'b1; exp_symbols = 32'h4A3B2C1C + k; exp_ctrl_flag = (k == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        exp_valid = 1'b0;
        chk("match_level3", fifo_level, 3);
        for (int k = 0; k < 3; k++) begin
            act_valid = 1'b1; act_symbols = 32'h4A3B2C1C + k; act_ctrl_flag = (k == 0) ? 4'b0001 : 4'b0000;
            tick();
            chk("match_pulse", mismatch_lane, 0);
        end
        act_valid = 1'b0;
        tick();
        chk("match_cmp", compare_cnt, 3);
        chk("match_mis", mismatch_cnt, 0);
        chk("match_pulse_last", mismatch_lane, 0);
        chk("match_level0", fifo_level, 0);
        lane_cfg = 2'b01; tick();
        chk("match_idle_lanes2", active_lanes, 2);
        lane_cfg = 2'b10; tick();
        chk("match_idle_lanes4", active_lanes, 4);

        // single-lane ctrl-flag corruption on lane 2
        exp_valid = 1'b1; exp_symbols = 32'h11BC2233; exp_ctrl_flag = 4'b0100; tick();
        exp_valid = 1'b0;
        act_valid = 1'b1; act_symbols = 32'h11BC2233; act_ctrl_flag = 4'b0000; tick();
        act_valid = 1'b0;
        chk("corr_no_early_pulse", mismatch_lane, 0);
        tick();
        chk("corr_pulse", mismatch_lane, 4'b0100);
        chk("corr_mis", mismatch_cnt, 1);
        chk("corr_sticky", lane_err_sticky, 4'b0100);
        chk("corr_cmp", compare_cnt, 4);
        tick();
        chk("corr_pulse_gone", mismatch_lane, 0);

        // lane masking with single-lane config, lane_cfg change ignored while running
        lane_cfg = 2'b00; tick();
        chk("mask_lanes1", active_lanes, 1);
        exp_valid = 1'b1; exp_symbols = 32'hA1B2C3D4; exp_ctrl_flag = 4'b0000; tick(); tick();
        exp_valid = 1'b0; lane_cfg = 2'b10;
        act_valid = 1'b1; act_symbols = 32'h5E6F70D4; act_ctrl_flag = 4'b1110; tick();
        chk("mask_run_frozen", active_lanes, 1);
        tick();
        chk("mask_pulse1", mismatch_lane, 0);
        act_valid = 1'b0; tick();
        chk("mask_pulse2", mismatch_lane, 0);
        chk("mask_drain_frozen", active_lanes, 1);
        chk("mask_mis", mismatch_cnt, 1);
        chk("mask_cmp", compare_cnt, 6);
        tick();
        chk("mask_idle_relatch", active_lanes, 4);

        // fill to full, overflow, then simultaneous push+pop at full
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            exp_valid = 1'b1; exp_symbols = {4{b}}; exp_ctrl_flag = 4'b0000;
            tick();
        end
        chk("full_level", fifo_level, 16);
        chk("full_not_ready", exp_ready, 0);
        exp_symbols = 32'hDEADBEEF; tick();
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_level", fifo_level, 16);
        act_valid = 1'b1; act_symbols = 32'h00000000; act_ctrl_flag = 4'b0000; exp_symbols = 32'h55555555;
        #1;
        chk("full_pushpop_ready", exp_ready, 1);
        tick();
        chk("full_pushpop_level", fifo_level, 16);
        exp_valid = 1'b0; act_valid = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        chk("full_flush_level", fifo_level, 0);
        chk("full_flush_cmp_done", compare_cnt, 7);
        chk("full_flush_mis", mismatch_cnt, 1);
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        chk("clr_ovf", overflow_err, 0);
        chk("clr_cmp", compare_cnt, 0);
        chk("clr_mis", mismatch_cnt, 0);
        chk("clr_sticky", lane_err_sticky, 0);

        // underflow with same-cycle push: no bypass compare
        act_valid = 1'b1; act_symbols = 32'h01020304; act_ctrl_flag = 4'b0000;
        exp_valid = 1'b1; exp_symbols = 32'h01020304; exp_ctrl_flag = 4'b0000;
        tick();
        act_valid = 1'b0; exp_valid = 1'b0;
        chk("unf_flag", underflow_err, 1);
        chk("unf_level", fifo_level, 1);
        tick();
        chk("unf_cmp", compare_cnt, 0);
        chk("unf_pulse", mismatch_lane, 0);

        // saturation: stream 65535 mismatching compares, then one more
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        chk("clr_unf", underflow_err, 0);
        exp_valid = 1'b1; exp_symbols = 32'h01020304; exp_ctrl_flag = 4'b0000;
        act_valid = 1'b1; act_symbols = 32'hFEFDFCFB; act_ctrl_flag = 4'b0000;
        repeat (65535) tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        tick();
        chk("sat_mis_max", mismatch_cnt, 16'hFFFF);
        chk("sat_cmp_max", compare_cnt, 16'hFFFF);
        chk("sat_level", fifo_level, 1);
        exp_valid = 1'b1; act_valid = 1'b1; tick();
        exp_valid = 1'b0; act_valid = 1'b0; tick();
        chk("sat_mis_hold", mismatch_cnt, 16'hFFFF);
        chk("sat_cmp_hold", compare_cnt, 16'hFFFF);
        chk("sat_pulse", mismatch_lane, 4'hF);
        chk("sat_sticky", lane_err_sticky, 4'hF);

        // clr_stats in the same cycle as a mismatch update
        act_valid = 1'b1; tick();
        act_valid = 1'b0; clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        chk("clrwin_mis", mismatch_cnt, 0);
        chk("clrwin_cmp", compare_cnt, 0);
        chk("clrwin_sticky", lane_err_sticky, 0);
        chk("clrwin_level", fifo_level, 0);

        // flush with 5 buffered entries; same-cycle push and pop are ignored
        for (int k = 0; k < 5; k++) begin
            exp_valid = 1'b1; exp_symbols = 32'h10 + k; exp_ctrl_flag = 4'b0000;
            tick();
        end
        chk("flush_pre_level", fifo_level, 5);
        flush = 1'b1; act_valid = 1'b1; act_symbols = 32'h10; act_ctrl_flag = 4'b0000;
        #1;
        chk("flush_not_ready", exp_ready, 0);
        tick();
        flush = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
        chk("flush_level", fifo_level, 0);
        tick();
        chk("flush_no_cmp", compare_cnt, 0);
        chk("flush_no_pulse", mismatch_lane, 0);
        lane_cfg = 2'b01; tick();
        chk("flush_idle_lanes", active_lanes, 2);
        lane_cfg = 2'b10;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_iso_lane_scoreboard.md
Name: dp_iso_lane_scoreboard

Overview:
Synthesizable checker that buffers expected ISO symbols and control-symbol flags from the reference model for up to MAX_LANES lanes. It compares them, in order, against the DUT's actual per-lane output. It sits in the DP verification environment between the reference-model output and the DUT's ISO lane outputs. It reports per-lane mismatch pulses, saturating counters and sticky protocol-error flags, honouring the configured active lane count (1/2/4).

Parameters:
AUX_DATA_WIDTH, 8, symbol width per lane
MAX_LANES, 4, number of physical lanes supported (1, 2 or 4)
FIFO_DEPTH, 16, expected-entry buffer depth (power of 2, >=2)
CNT_WIDTH, 16, width of compare and mismatch counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lane_cfg  in  2  active lanes: 00=1, 01=2, 10=4, 11=reserved (treated as MAX_LANES)
flush  in  1  discard all buffered expected entries
clr_stats  in  1  clear counters and sticky flags
exp_valid  in  1  expected entry present
exp_symbols  in  MAX_LANES*AUX_DATA_WIDTH  expected symbols, lane0 in LSBs
exp_ctrl_flag  in  MAX_LANES  expected control-symbol flags
exp_ready  out  1  buffer not full
act_valid  in  1  DUT output present
act_symbols  in  MAX_LANES*AUX_DATA_WIDTH  actual symbols, lane0 in LSBs
act_ctrl_flag  in  MAX_LANES  actual control-symbol flags
mismatch_lane  out  MAX_LANES  one-cycle pulse per mismatching lane
mismatch_cnt  out  CNT_WIDTH  compares with at least one mismatching lane
compare_cnt  out  CNT_WIDTH  total compares performed
lane_err_sticky  out  MAX_LANES  lane has mismatched since last clear
overflow_err  out  1  sticky: exp_valid while full
underflow_err  out  1  sticky: act_valid while empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered entries
active_lanes  out  3  latched lane count (1, 2 or 4)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Outputs: all counters, flags and pulses 0; fifo_level=0; exp_ready=1; active_lanes=min(4,MAX_LANES).
  - FSM goes to IDLE.
- FIFO entry: {exp_ctrl_flag, exp_symbols} for all MAX_LANES.
  - Push when exp_valid && exp_ready.
  - Pop when act_valid && fifo_level!=0.
  - Push and pop in the same cycle are both accepted, including when full (level unchanged). exp_ready is combinational: !full || (act_valid && level!=0).
- exp_valid && !exp_ready: entry dropped, overflow_err set.
- act_valid with level==0: no compare, no pop, underflow_err set.
  - No bypass: an expected entry pushed in the same cycle is not compared.
- Compare latency 1 cycle: the pop at edge N drives mismatch_lane and counter updates visible after edge N+1.
  - The compare stage registers the popped entry and actual data.
  - Lane i mismatches if i < active_lanes and (symbol differs or ctrl flag differs).
  - Inactive lanes never mismatch.
- Counters:
  - compare_cnt +1 per compare.
  - mismatch_cnt +1 per compare with |mismatch_lane.
  - Both saturate at all-ones.
  - lane_err_sticky |= mismatch_lane.
- clr_stats:
  - Clears counters, sticky flags, overflow_err and underflow_err next cycle.
  - Beats an increment or set in the same cycle.
  - Does not touch the FIFO.
- flush:
  - Level goes to 0 next cycle, and any pop or push that cycle is ignored.
  - A compare already in the compare stage still completes.
  - exp_ready is 0 during a flush cycle.
- FSM:
  - IDLE: level==0, no compare in flight. lane_cfg is latched into active_lanes every cycle. Go to RUN on push.
  - RUN: active_lanes frozen. Go to DRAIN on level reaching 0 with a compare in flight; go to IDLE on flush.
  - DRAIN: final compare completes. Go to IDLE next cycle, or to RUN if a push occurs.
- Lane configuration:
  - Changes to lane_cfg in RUN/DRAIN are ignored until IDLE.
  - Encodings that select more lanes than MAX_LANES clamp to MAX_LANES.
- Reset mid-operation: reset drops all buffered entries and any in-flight compare; no pulse is produced.

Decomposition:
- Package dp_scb_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - lane_cfg encoding constants;
  - a function decoding lane_cfg to a lane count with MAX_LANES clamp.
- One sub-module, dp_scb_fifo: parametrised sync FIFO (WIDTH, DEPTH) with level, full/empty, simultaneous push/pop and flush.
- Compare stage, counters and FSM live in the top.

Test Plan:
- Setup for all scenarios: MAX_LANES=4, lane_cfg=10.
- In-order match: push 3 entries (lane0=8'h1C..), then 3 act_valid with identical data -> compare_cnt=3, mismatch_cnt=0, no mismatch_lane pulse, fifo_level returns 0, FSM back to IDLE.
- Single-lane corruption: expected lane2=8'hBC/ctrl=1, actual lane2=8'hBC/ctrl=0 -> mismatch_lane=4'b0100 one cycle after act_valid, mismatch_cnt=1, lane_err_sticky=4'b0100.
- Lane-count masking: lane_cfg=00 in IDLE, then lane1..3 corrupted -> no mismatch.
  - Change lane_cfg to 10 while in RUN -> active_lanes stays 1 until IDLE.
- Full/overflow: 16 pushes, 17th push with no pop -> exp_ready=0, overflow_err=1, fifo_level=16.
  - Then simultaneous push+pop -> both accepted, level stays 16.
- Underflow: act_valid with empty FIFO plus same-cycle exp_valid -> underflow_err=1, compare_cnt=0, fifo_level=1.
- Clear/flush/saturation:
  - Force mismatch_cnt to 16'hFFFF, then another mismatch -> stays FFFF.
  - clr_stats and mismatch in the same cycle -> counters 0.
  - flush with 5 entries buffered -> level 0 next cycle, FSM goes to IDLE.
